bcd_cnt_param: RTL

Parametrised, cascadable N-digit BCD up/down counter; the next-generation replacement for the fixed 3-digit BCD counter top. It counts single-cycle `cin` pulses in packed BCD, supports direction control, synchronous clear and parallel load with digit validation, and produces a combinational terminal-count carry/borrow for chaining. It sits in display and timebase paths wherever decimal counts are consumed directly.

---
 rtl/bcd_cnt_param.sv | 102 ++++++++++
 1 files changed

// File: rtl/bcd_cnt_param.sv
// Parametrised cascadable N-digit packed-BCD up/down counter with clear, validated load and
// combinational terminal-count carry/borrow. Define BCDCNT_SAT_EN to hold at terminal count.
module bcd_cnt_param #(
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  cin,
  input  logic                  dir,
  output logic [4*DIGITS-1:0]   q,
  output logic                  cout,
  output logic                  load_err
);

  logic [4*DIGITS-1:0] q_q, q_d;
  logic                err_q, err_d;
  logic [4*DIGITS-1:0] step_val;
  logic [4*DIGITS-1:0] clamp_val;
  logic                clamp_hit;
  logic                all9, all0;
  logic                terminal;
  logic                sat_hold;

  // Ripple step across digits; chain carries the +1/-1 into the next digit.
  always_comb begin
    logic [3:0] dig;
    logic [3:0] ld;
    logic       chain;
    all9      = 1'b1;
    all0      = 1'b1;
    step_val  = q_q;
    clamp_val = load_val;
    clamp_hit = 1'b0;
    chain     = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      dig = q_q[4*i +: 4];
      ld  = load_val[4*i +: 4];
      if (dig != 4'd9) all9 = 1'b0;
      if (dig != 4'd0) all0 = 1'b0;
      if (chain) begin
        if (dir) begin
          if (dig == 4'd9) begin
            step_val[4*i +: 4] = 4'd0;
          end else begin
            step_val[4*i +: 4] = dig + 4'd1;
            chain = 1'b0;
          end
        end else begin
          if (dig == 4'd0) begin
            step_val[4*i +: 4] = 4'd9;
          end else begin
            step_val[4*i +: 4] = dig - 4'd1;
            chain = 1'b0;
          end
        end
      end
      if (ld > 4'd9) begin
        clamp_val[4*i +: 4] = 4'd9;
        clamp_hit = 1'b1;
      end
    end
  end

  assign terminal = dir ? all9 : all0;

`ifdef BCDCNT_SAT_EN
  assign sat_hold = terminal;
`else
  assign sat_hold = 1'b0;
`endif

  always_comb begin
    q_d   = q_q;
    err_d = 1'b0;
    if (clr) begin
      q_d = '0;
    end else if (load) begin
      q_d   = clamp_val;
      err_d = clamp_hit;
    end else if (cin && !sat_hold) begin
      q_d = step_val;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q   <= '0;
      err_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      err_q <= err_d;
    end
  end

  assign q        = q_q;
  assign load_err = err_q;
  assign cout     = rst & cin & ~clr & ~load & terminal;

endmodule
